sc_regreader: RTL and testbench
===============================

# sc_regreader

Register-bank reader/transmitter: snapshots the outputs of ROWS general-purpose data registers on request and serializes them, one row per frame, to a MAX7219-style LED-matrix driver (CS, SCLK, DIN). This block is the read side of the register bank. Game logic writes rows through the registers' load/clear inputs, and this block reads the registers' output buses and carries them off-chip to the display.

## Interface
- REGREADER_DATAWIDTH, 8, bits per row; fixed at 8 for the driver frame format
- REGREADER_ROWS, 8, number of rows per refresh; 1..255
- REGREADER_CLKDIV, 4, system cycles per SCLK half-period; ≥1
- SC_REGREADER_CLOCK_50  in  1  system clock; all logic on the rising edge
- SC_REGREADER_RESET_InLow  in  1  reset; synchronous, active-low
- SC_REGREADER_start_InLow  in  1  refresh request; active-low, level-sampled in IDLE only
- SC_REGREADER_data_InBUS  in  ROWS*8  register outputs; row r occupies bits [8r+7:8r]
- SC_REGREADER_busy_Out  out  1  high from the cycle after start is accepted until DONE is left
- SC_REGREADER_done_Out  out  1  one-cycle pulse when the last frame's latch completes
- SC_REGREADER_cs_OutLow  out  1  driver chip select; active-low
- SC_REGREADER_sclk_Out  out  1  serial clock; idles low
- SC_REGREADER_din_Out  out  1  serial data; MSB first; changes only while SCLK is low

## Operation
- States: IDLE, LOAD, SHIFT, LATCH, DONE.
- IDLE: when start_InLow = 0 at an edge, capture the whole data_InBUS into the snapshot, set row = 0 and busy = 1, and go to LOAD. Rows are sent only from the snapshot, so register writes during a refresh never tear a frame.
- LOAD (1 cycle):
  - frame = {row+1 [7:0], snapshot row [7:0]}, 16 bits.
  - cs = 0, sclk = 0, din = frame[15].
  - bitcnt = 0, divcnt = 0.
  - Go to SHIFT.
- SHIFT: divcnt counts 0..CLKDIV-1. When divcnt = CLKDIV-1:
  - Toggle sclk and clear divcnt.
  - On a high→low toggle, shift the frame left, present the next bit on din, and increment bitcnt.
  - On the high→low toggle where bitcnt = 15, go to LATCH instead.
- LATCH: cs = 1, sclk = 0, hold for CLKDIV cycles. Then:
  - if row = ROWS-1, go to DONE;
  - otherwise row++ and go to LOAD.
- DONE (1 cycle): done = 1, busy = 0, then IDLE.
- start_InLow is ignored in every state other than IDLE. A start held low continuously retriggers a refresh one cycle after DONE.
- Address arithmetic is 8-bit: row+1, never zero. Counter widths are $clog2 of their range, minimum 1 bit.

## Timing
- Reset values: cs_OutLow = 1, sclk_Out = 0, din_Out = 0, busy_Out = 0, done_Out = 0, state = IDLE.
- Reset asserted mid-operation: all outputs return to reset values at the next edge. The snapshot and counters clear, and no partial frame completes.
- All outputs are registered.
- Each bit lasts 2*CLKDIV cycles: CLKDIV with SCLK low, then CLKDIV with SCLK high. The driver samples DIN on SCLK rising, and DIN is stable for CLKDIV cycles before that edge.
- Per frame: 1 (LOAD) + 32*CLKDIV (SHIFT) + CLKDIV (LATCH) cycles. CS is high for at least CLKDIV cycles between frames.
- Start accepted at edge k gives the first LOAD at k+1. done pulses at k + 1 + ROWS*(1+33*CLKDIV). Defaults: 133 cycles per frame, done at k+1065.

## Structure
- Shared package holds:
  - state encoding localparams (IDLE, LOAD, SHIFT, LATCH, DONE);
  - FRAME_BITS = 16;
  - ADDR_BITS = 8.
- One natural sub-module, sc_regreader_shift. It holds the 16-bit frame shifter, the SCLK divider and the bit counter. Interface: load pulse in, frame in, din/sclk out, frame_end pulse out.
- The top level keeps the FSM, row counter, snapshot and CS/busy/done.

## Test plan
- Reset then idle: hold start high for 100 cycles → cs = 1, sclk = 0, din = 0, busy = 0, done never pulses.
- Single refresh, defaults, row r = 8'hA0+r: capture with the bench's DIN sampler on SCLK rising → 8 frames 16'h01A0, 16'h02A1 … 16'h08A7. Exactly 16 SCLK rises per CS-low window. done pulses exactly 1065 cycles after start is accepted.
- Snapshot integrity: start, then change row 3 to 8'hFF at cycle 10 → frame 4 still carries 8'hA3.
- Start while busy: pulse start low at cycle 200 of a refresh → no restart and done timing unchanged. Start held low continuously → the next refresh LOAD occurs 1 cycle after DONE.
- Mid-frame reset: assert reset during bit 7 of frame 2 → next edge cs = 1, sclk = 0, busy = 0. A new start afterwards sends frame 16'h01xx first.
- Parameter corner, CLKDIV = 1, ROWS = 1: row 0 = 8'h5A → one frame 16'h015A. SCLK period is 2 cycles, done at k+35.

Source files
------------

// File: rtl/sc_regreader_pkg.sv
// sc_regreader_pkg: shared state encoding, frame constants and counter sizing helper
package sc_regreader_pkg;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_LATCH = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      LOAD  = ST_LOAD,
      SHIFT = ST_SHIFT,
      LATCH = ST_LATCH,
      DONE  = ST_DONE
   } state_e;
   localparam int FRAME_BITS = 16;
   localparam int ADDR_BITS  = 8;
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sc_regreader_shift.sv
// sc_regreader_shift: 16-bit frame serializer with SCLK divider and bit counter
// Ports: clk_i/rst_ni (sync, active-low), load_i pulse with frame_i,
//        din_o/sclk_o serial pins, frame_end_o pulse on the final SCLK fall.
module sc_regreader_shift
   import sc_regreader_pkg::*;
#(
   parameter int CLKDIV = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic [FRAME_BITS-1:0] frame_i,
   output logic                  din_o,
   output logic                  sclk_o,
   output logic                  frame_end_o
);
   localparam int DW = cnt_bits(CLKDIV);
   localparam int BW = cnt_bits(FRAME_BITS);
   localparam logic [DW-1:0] DIV_MAX = DW'(CLKDIV - 1);
   localparam logic [BW-1:0] BIT_MAX = BW'(FRAME_BITS - 1);
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DW-1:0]         div_q, div_d;
   logic                  sclk_q, sclk_d, active_q, active_d;
   logic                  tick, fall, adv;
   // tick ends a half-period; fall is a high->low SCLK edge, where the next bit is presented
   assign tick        = active_q && div_q == DIV_MAX;
   assign fall        = tick && sclk_q;
   assign frame_end_o = fall && bit_q == BIT_MAX;
   assign adv         = fall && !frame_end_o;
   assign frame_d  = load_i ? frame_i : adv ? frame_q << 1 : frame_q;
   assign bit_d    = load_i ? '0 : adv ? bit_q + 1'b1 : bit_q;
   assign div_d    = (load_i || tick) ? '0 : active_q ? div_q + 1'b1 : div_q;
   assign sclk_d   = load_i ? 1'b0 : tick ? !sclk_q : sclk_q;
   assign active_d = load_i ? 1'b1 : frame_end_o ? 1'b0 : active_q;
   assign din_o    = frame_q[FRAME_BITS-1];
   assign sclk_o   = sclk_q;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         frame_q  <= '0;
         bit_q    <= '0;
         div_q    <= '0;
         sclk_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         frame_q  <= frame_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
         sclk_q   <= sclk_d;
         active_q <= active_d;
      end
   end
endmodule

// File: rtl/sc_regreader.sv
// sc_regreader: snapshots ROWS register outputs and sends them as MAX7219-style frames
// Ports: SC_REGREADER_CLOCK_50 clock, SC_REGREADER_RESET_InLow sync active-low reset,
//        SC_REGREADER_start_InLow refresh request, SC_REGREADER_data_InBUS row bus,
//        busy/done status, cs_OutLow/sclk_Out/din_Out serial driver pins.
module sc_regreader
   import sc_regreader_pkg::*;
#(
   parameter int REGREADER_DATAWIDTH = 8,
   parameter int REGREADER_ROWS      = 8,
   parameter int REGREADER_CLKDIV    = 4
) (
   input  logic                                        SC_REGREADER_CLOCK_50,
   input  logic                                        SC_REGREADER_RESET_InLow,
   input  logic                                        SC_REGREADER_start_InLow,
   input  logic [REGREADER_ROWS*REGREADER_DATAWIDTH-1:0] SC_REGREADER_data_InBUS,
   output logic                                        SC_REGREADER_busy_Out,
   output logic                                        SC_REGREADER_done_Out,
   output logic                                        SC_REGREADER_cs_OutLow,
   output logic                                        SC_REGREADER_sclk_Out,
   output logic                                        SC_REGREADER_din_Out
);
   localparam int DW = cnt_bits(REGREADER_CLKDIV);
   localparam logic [DW-1:0]        LAT_MAX  = DW'(REGREADER_CLKDIV - 1);
   localparam logic [ADDR_BITS-1:0] ROW_LAST = ADDR_BITS'(REGREADER_ROWS - 1);
   state_e                                                state_q, state_d;
   logic [ADDR_BITS-1:0]                                  row_q, row_d;
   logic [REGREADER_ROWS-1:0][REGREADER_DATAWIDTH-1:0]    snap_q, snap_d;
   logic [DW-1:0]                                         lcnt_q, lcnt_d;
   logic                                                  cs_q, cs_d, busy_q, busy_d, done_q, done_d;
   logic                                                  load, frame_end;
   logic [FRAME_BITS-1:0]                                 frame;
   // the snapshot is shifted down one row per frame, so the current row is always entry 0
   assign frame = {row_q + 8'd1, snap_q[0]};
   sc_regreader_shift #(.CLKDIV(REGREADER_CLKDIV)) u_shift (
      .clk_i       (SC_REGREADER_CLOCK_50),
      .rst_ni      (SC_REGREADER_RESET_InLow),
      .load_i      (load),
      .frame_i     (frame),
      .din_o       (SC_REGREADER_din_Out),
      .sclk_o      (SC_REGREADER_sclk_Out),
      .frame_end_o (frame_end)
   );
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      snap_d  = snap_q;
      lcnt_d  = lcnt_q;
      cs_d    = cs_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: if (!SC_REGREADER_start_InLow) begin
            snap_d  = SC_REGREADER_data_InBUS;
            row_d   = '0;
            busy_d  = 1'b1;
            state_d = LOAD;
         end
         LOAD: begin
            load    = 1'b1;
            cs_d    = 1'b0;
            state_d = SHIFT;
         end
         SHIFT: if (frame_end) begin
            cs_d    = 1'b1;
            lcnt_d  = '0;
            state_d = LATCH;
         end
         LATCH: if (lcnt_q != LAT_MAX) begin
            lcnt_d = lcnt_q + 1'b1;
         end else if (row_q == ROW_LAST) begin
            state_d = DONE;
         end else begin
            row_d   = row_q + 8'd1;
            snap_d  = snap_q >> REGREADER_DATAWIDTH;
            state_d = LOAD;
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge SC_REGREADER_CLOCK_50) begin
      if (!SC_REGREADER_RESET_InLow) begin
         state_q <= IDLE;
         row_q   <= '0;
         snap_q  <= '0;
         lcnt_q  <= '0;
         cs_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         snap_q  <= snap_d;
         lcnt_q  <= lcnt_d;
         cs_q    <= cs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign SC_REGREADER_cs_OutLow = cs_q;
   assign SC_REGREADER_busy_Out  = busy_q;
   assign SC_REGREADER_done_Out  = done_q;
endmodule

// File: tb/tb_sc_regreader.sv
// tb_sc_regreader: randomized self-checking bench for sc_regreader with a frame-level model
module tb_sc_regreader;
   localparam int ROWS = 8;
   localparam int CD   = 4;
   localparam int DONE_LAT = 1 + ROWS * (1 + 33 * CD);
   logic clk = 0, rst_n = 0, start = 1, start2 = 1;
   logic [ROWS*8-1:0] bus = '0;
   logic [7:0] bus2 = '0;
   logic cs, sclk, din, busy, done;
   logic cs2, sclk2, din2, busy2, done2;
   int tests = 0, fails = 0;
   sc_regreader dut (
      .SC_REGREADER_CLOCK_50   (clk),
      .SC_REGREADER_RESET_InLow(rst_n),
      .SC_REGREADER_start_InLow(start),
      .SC_REGREADER_data_InBUS (bus),
      .SC_REGREADER_busy_Out   (busy),
      .SC_REGREADER_done_Out   (done),
      .SC_REGREADER_cs_OutLow  (cs),
      .SC_REGREADER_sclk_Out   (sclk),
      .SC_REGREADER_din_Out    (din)
   );
   sc_regreader #(.REGREADER_ROWS(1), .REGREADER_CLKDIV(1)) dut2 (
      .SC_REGREADER_CLOCK_50   (clk),
      .SC_REGREADER_RESET_InLow(rst_n),
      .SC_REGREADER_start_InLow(start2),
      .SC_REGREADER_data_InBUS (bus2),
      .SC_REGREADER_busy_Out   (busy2),
      .SC_REGREADER_done_Out   (done2),
      .SC_REGREADER_cs_OutLow  (cs2),
      .SC_REGREADER_sclk_Out   (sclk2),
      .SC_REGREADER_din_Out    (din2)
   );
   always #5 clk = ~clk;
   // driver-side receiver: DIN sampled on each SCLK rise inside a CS-low window
   logic [15:0] fq[$], fq2[$];
   int nq[$], nq2[$];
   logic [15:0] sh = '0, sh2 = '0;
   int nb = 0, nb2 = 0;
   logic cs_p = 1, sclk_p = 0, cs2_p = 1, sclk2_p = 0;
   always @(negedge clk) begin
      if (cs_p && !cs) begin sh = '0; nb = 0; end
      if (!cs && !sclk_p && sclk) begin sh = {sh[14:0], din}; nb++; end
      if (!cs_p && cs) begin fq.push_back(sh); nq.push_back(nb); end
      cs_p = cs; sclk_p = sclk;
      if (cs2_p && !cs2) begin sh2 = '0; nb2 = 0; end
      if (!cs2 && !sclk2_p && sclk2) begin sh2 = {sh2[14:0], din2}; nb2++; end
      if (!cs2_p && cs2) begin fq2.push_back(sh2); nq2.push_back(nb2); end
      cs2_p = cs2; sclk2_p = sclk2;
   end
   function automatic logic [15:0] exp_frame(input int r, input logic [7:0] b);
      return {8'(r + 1), b};
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst_n = 0; start = 1; start2 = 1;
      repeat (3) step();
      rst_n = 1;
      step();
      fq.delete(); nq.delete(); fq2.delete(); nq2.delete();
      for (int i = 0; i < 100; i++) begin
         tests++;
         if ({cs, sclk, din, busy, done} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_idle cycle %0d: {cs,sclk,din,busy,done}=%b want 10000", i, {cs, sclk, din, busy, done});
         end
         step();
      end
      tests++;
      if ({cs2, sclk2, din2, busy2, done2} !== 5'b10000) begin
         fails++;
         $display("FAIL reset_idle2: got %b want 10000", {cs2, sclk2, din2, busy2, done2});
      end
      tests++;
      if (fq.size() !== 0) begin
         fails++;
         $display("FAIL idle_no_frames: got %0d frames want 0", fq.size());
      end
   endtask
   task automatic test_refresh(input bit rnd);
      logic [7:0] rows[ROWS];
      int n = 0;
      bit got = 0;
      for (int r = 0; r < ROWS; r++) begin
         rows[r] = rnd ? 8'($urandom) : 8'(8'hA0 + r);
         bus[r*8 +: 8] = rows[r];
      end
      fq.delete(); nq.delete();
      start = 0; step(); start = 1;
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_start: got %b want 1", busy); end
      while (n < 5000 && !got) begin
         if (n == 10) bus[31:24] = rnd ? ~rows[3] : 8'hFF;
         step(); n++;
         if (done) got = 1;
      end
      tests++;
      if (n !== DONE_LAT) begin fails++; $display("FAIL done_latency: got %0d want %0d", n, DONE_LAT); end
      step();
      tests++;
      if ({done, busy, cs} !== 3'b001) begin
         fails++;
         $display("FAIL after_done {done,busy,cs}: got %b want 001", {done, busy, cs});
      end
      tests++;
      if (fq.size() !== ROWS) begin fails++; $display("FAIL frame_count: got %0d want %0d", fq.size(), ROWS); end
      for (int r = 0; r < ROWS && r < fq.size(); r++) begin
         tests++;
         if (fq[r] !== exp_frame(r, rows[r])) begin
            fails++;
            $display("FAIL frame[%0d]: got %h want %h", r, fq[r], exp_frame(r, rows[r]));
         end
         tests++;
         if (nq[r] !== 16) begin fails++; $display("FAIL sclk_rises[%0d]: got %0d want 16", r, nq[r]); end
      end
   endtask
   task automatic test_start_while_busy();
      int n = 0;
      bit got = 0, restarted = 0;
      for (int r = 0; r < ROWS; r++) bus[r*8 +: 8] = 8'($urandom);
      start = 0; step(); start = 1;
      while (n < 5000 && !got) begin
         start = (n == 200) ? 1'b0 : 1'b1;
         step(); n++;
         start = 1;
         if (done) got = 1;
      end
      tests++;
      if (n !== DONE_LAT) begin fails++; $display("FAIL busy_start_latency: got %0d want %0d", n, DONE_LAT); end
      for (int i = 0; i < 50; i++) begin
         step();
         if (busy || !cs) restarted = 1;
      end
      tests++;
      if (restarted !== 1'b0) begin fails++; $display("FAIL busy_start_restart: got %b want 0", restarted); end
   endtask
   task automatic test_held_start();
      int n = 0, m = 0;
      bit got = 0;
      for (int r = 0; r < ROWS; r++) bus[r*8 +: 8] = 8'($urandom);
      start = 0; step();
      while (n < 5000 && !got) begin step(); n++; if (done) got = 1; end
      tests++;
      if (n !== DONE_LAT) begin fails++; $display("FAIL held_first_latency: got %0d want %0d", n, DONE_LAT); end
      while (cs && m < 20) begin step(); m++; end
      start = 1;
      tests++;
      if (m !== 2) begin fails++; $display("FAIL held_retrigger_gap: got %0d want 2", m); end
      n = 1; got = 0;
      while (n < 5000 && !got) begin step(); n++; if (done) got = 1; end
      tests++;
      if (n !== DONE_LAT) begin fails++; $display("FAIL held_second_latency: got %0d want %0d", n, DONE_LAT); end
      repeat (3) step();
   endtask
   task automatic test_mid_reset();
      logic [7:0] rows[ROWS];
      int n = 0;
      bit got = 0;
      for (int r = 0; r < ROWS; r++) bus[r*8 +: 8] = 8'($urandom);
      start = 0; step(); start = 1;
      while (n < 196) begin step(); n++; end
      tests++;
      if ({cs, sclk} !== 2'b01) begin fails++; $display("FAIL mid_precond {cs,sclk}: got %b want 01", {cs, sclk}); end
      rst_n = 0; step();
      tests++;
      if ({cs, sclk, din, busy, done} !== 5'b10000) begin
         fails++;
         $display("FAIL mid_reset outputs: got %b want 10000", {cs, sclk, din, busy, done});
      end
      rst_n = 1; step();
      fq.delete(); nq.delete();
      for (int r = 0; r < ROWS; r++) begin
         rows[r] = 8'($urandom);
         bus[r*8 +: 8] = rows[r];
      end
      start = 0; step(); start = 1;
      n = 0;
      while (n < 5000 && !got) begin step(); n++; if (done) got = 1; end
      step();
      tests++;
      if (fq.size() !== ROWS) begin fails++; $display("FAIL post_reset_count: got %0d want %0d", fq.size(), ROWS); end
      tests++;
      if (fq.size() == 0 || fq[0] !== exp_frame(0, rows[0])) begin
         fails++;
         $display("FAIL post_reset_first: got %h want %h", fq.size() ? fq[0] : 16'h0, exp_frame(0, rows[0]));
      end
   endtask
   task automatic test_corner();
      int n = 0, r1 = -1, r2 = -1;
      bit got = 0;
      logic sp = 0;
      bus2 = 8'h5A;
      fq2.delete(); nq2.delete();
      start2 = 0; step(); start2 = 1;
      while (n < 500 && !got) begin
         step(); n++;
         if (!sp && sclk2) begin
            if (r1 < 0) r1 = n; else if (r2 < 0) r2 = n;
         end
         sp = sclk2;
         if (done2) got = 1;
      end
      tests++;
      if (n !== 35) begin fails++; $display("FAIL corner_done_latency: got %0d want 35", n); end
      tests++;
      if (r2 - r1 !== 2) begin fails++; $display("FAIL corner_sclk_period: got %0d want 2", r2 - r1); end
      step();
      tests++;
      if (fq2.size() !== 1 || fq2[0] !== 16'h015A || nq2[0] !== 16) begin
         fails++;
         $display("FAIL corner_frame: got n=%0d frame=%h rises=%0d want 1/015a/16", fq2.size(),
                  fq2.size() ? fq2[0] : 16'h0, nq2.size() ? nq2[0] : 0);
      end
   endtask
   initial begin
      test_reset();
      test_refresh(0);
      test_refresh(1);
      test_start_while_busy();
      test_held_start();
      test_mid_reset();
      test_corner();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
